rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/rf_scoreboard.sv | 59 +++++
 rtl/rf_write_arbiter.sv | 118 +++++++++++
 tb/tb_rf_write_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : cpu_pkg                                                  |
// | Description : Shared register-file geometry, arbiter defaults, grant   |
// |               encoding and an address-match helper.                   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package cpu_pkg;

  localparam int XLEN_DEFAULT     = 32;
  localparam int NREG             = 32;
  localparam int REG_ADDR_W       = 5;
  localparam int MAX_WAIT_DEFAULT = 4;

  // Wide enough for the largest supported MAX_WAIT (15).
  localparam int WAIT_W = 4;

  // Which requester owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

  // x0 is hard-wired to zero, so it never matches anything.
  function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] b);
    return (a == b) && (a != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rf_scoreboard                                            |
// | Description : Pending-write mask for registers targeted by the         |
// |               long-latency unit, plus busy lookups.                    |
// | Ports       : clk, rst_n       - clock, async active-low reset         |
// |               set_en/set_rd    - mark rd pending (dispatch)            |
// |               clr_en/clr_rd    - clear rd (port-B write accepted)      |
// |               b_valid/b_rd     - result in flight, not yet accepted    |
// |               rs1/rs2          - decode source addresses               |
// |               rs1_busy/rs2_busy- source has an outstanding write       |
// |               a_rd/a_pending   - WAW lookup for the port-A request     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module rf_scoreboard
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] a_rd,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  a_pending
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;

  // Clear before set: a new dispatch to the same rd that retires this
  // cycle must remain pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (clr_en) w_pending_nxt[clr_rd] = 1'b0;
    if (set_en) w_pending_nxt[set_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  // A result sitting on port B still counts as busy until it is written.
  always_comb begin
    rs1_busy  = (rs1 != '0) && (r_pending[rs1] || (b_valid && addr_hit(b_rd, rs1)));
    rs2_busy  = (rs2 != '0) && (r_pending[rs2] || (b_valid && addr_hit(b_rd, rs2)));
    a_pending = (a_rd != '0) && r_pending[a_rd];
  end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rf_write_arbiter                                         |
// | Description : Arbitrates the single register-file write port between  |
// |               pipeline write-back (A) and the long-latency unit (B),   |
// |               with starvation guard and WAW protection.                |
// | Ports       : clk, rst_n                - clock, async active-low rst |
// |               a_valid/a_rd/a_wdata/a_ready - pipeline write-back      |
// |               b_issue/b_issue_rd        - long-latency dispatch       |
// |               b_valid/b_rd/b_wdata/b_ready - long-latency result      |
// |               rs1/rs2, rs1_busy/rs2_busy - decode hazard lookup       |
// |               rf_wen/rf_rd/rf_wdata      - registered RF write port   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module rf_write_arbiter
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int XLEN     = XLEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]       a_wdata,
  output logic                  a_ready,
  input  logic                  b_issue,
  input  logic [REG_ADDR_W-1:0] b_issue_rd,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]       b_wdata,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_force_b;
  logic              w_a_pending;
  logic              w_a_grant;
  logic              w_b_grant;
  grant_e            w_grant;

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (b_issue),
    .set_rd    (b_issue_rd),
    .clr_en    (w_b_grant),
    .clr_rd    (b_rd),
    .b_valid   (b_valid),
    .b_rd      (b_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .a_rd      (a_rd),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .a_pending (w_a_pending)
  );

  // Readies depend only on inputs, the wait counter and the pending mask,
  // never on the rf_* output register.
  always_comb begin
    w_force_b = b_valid && (r_wait_cnt == MAX_WAIT_C);
    // A stalls on a forced B grant, or when its rd still awaits a B write
    // (letting A through would be overwritten by the older B result).
    a_ready   = !w_force_b && !(a_valid && w_a_pending);
    w_a_grant = a_valid && a_ready;
    b_ready   = w_force_b || !w_a_grant;
    w_b_grant = b_valid && b_ready;
    w_grant   = GNT_NONE;
    if (w_a_grant)      w_grant = GNT_A;
    else if (w_b_grant) w_grant = GNT_B;
  end

  // Counts consecutive cycles B has been refused; saturates at MAX_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!b_valid || w_b_grant) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != MAX_WAIT_C) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Writes to x0 are accepted but suppressed at the RF port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      case (w_grant)
        GNT_A: begin
          rf_wen   <= (a_rd != '0);
          rf_rd    <= a_rd;
          rf_wdata <= a_wdata;
        end
        GNT_B: begin
          rf_wen   <= (b_rd != '0);
          rf_rd    <= b_rd;
          rf_wdata <= b_wdata;
        end
        default: rf_wen <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_rf_write_arbiter                                      |
// | Description : Directed self-checking bench for rf_write_arbiter.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_wdata;
  logic        a_ready;
  logic        b_issue;
  logic [4:0]  b_issue_rd;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_wdata;
  logic        b_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  rf_write_arbiter #(.MAX_WAIT(4), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_rd       (a_rd),
    .a_wdata    (a_wdata),
    .a_ready    (a_ready),
    .b_issue    (b_issue),
    .b_issue_rd (b_issue_rd),
    .b_valid    (b_valid),
    .b_rd       (b_rd),
    .b_wdata    (b_wdata),
    .b_ready    (b_ready),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rf_wen     (rf_wen),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; a_rd = '0; a_wdata = '0;
    b_issue = 1'b0; b_issue_rd = '0; b_valid = 1'b0; b_rd = '0; b_wdata = '0;
    rs1 = '0; rs2 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Single port-A write
    a_valid = 1'b1; a_rd = 5'd5; a_wdata = 32'h11;
    #1;
    chk("a_alone_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    chk("a_alone_wen", 32'(rf_wen), 32'd1);
    chk("a_alone_rd", 32'(rf_rd), 32'd5);
    chk("a_alone_wdata", rf_wdata, 32'h11);
    tick();
    chk("a_alone_wen_pulse", 32'(rf_wen), 32'd0);

    // Starvation guard: B forced on its 5th waiting cycle
    b_issue = 1'b1; b_issue_rd = 5'd7;
    tick();
    b_issue = 1'b0;
    rs1 = 5'd7;
    #1;
    chk("issue7_busy", 32'(rs1_busy), 32'd1);
    a_valid = 1'b1; a_rd = 5'd1; a_wdata = 32'hA0;
    b_valid = 1'b1; b_rd = 5'd7; b_wdata = 32'hB7;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk($sformatf("starve_a_ready_c%0d", k), 32'(a_ready), (k == 5) ? 32'd0 : 32'd1);
      chk($sformatf("starve_b_ready_c%0d", k), 32'(b_ready), (k == 5) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("starve_rf_rd_c%0d", k), 32'(rf_rd), (k == 5) ? 32'd7 : 32'd1);
      if (k == 5) begin
        chk("starve_rf_wdata", rf_wdata, 32'hB7);
        b_valid = 1'b0;
      end
    end
    #1;
    chk("starve_c6_a_ready", 32'(a_ready), 32'd1);
    chk("starve_7_cleared", 32'(rs1_busy), 32'd0);
    tick();
    chk("starve_c6_rf_rd", 32'(rf_rd), 32'd1);
    a_valid = 1'b0;

    // WAW protection on rd=9
    b_issue = 1'b1; b_issue_rd = 5'd9;
    tick();
    b_issue = 1'b0;
    rs1 = 5'd9;
    a_valid = 1'b1; a_rd = 5'd9; a_wdata = 32'h99;
    #1;
    chk("waw_rs1_busy", 32'(rs1_busy), 32'd1);
    chk("waw_a_blocked", 32'(a_ready), 32'd0);
    tick();
    chk("waw_no_write", 32'(rf_wen), 32'd0);
    b_valid = 1'b1; b_rd = 5'd9; b_wdata = 32'h55;
    #1;
    chk("waw_a_blocked2", 32'(a_ready), 32'd0);
    chk("waw_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    chk("waw_b_wen", 32'(rf_wen), 32'd1);
    chk("waw_b_rd", 32'(rf_rd), 32'd9);
    chk("waw_b_wdata", rf_wdata, 32'h55);
    #1;
    chk("waw_a_released", 32'(a_ready), 32'd1);
    chk("waw_rs1_free", 32'(rs1_busy), 32'd0);
    tick();
    chk("waw_a_wdata", rf_wdata, 32'h99);
    a_valid = 1'b0;

    // Write to x0
    a_valid = 1'b1; a_rd = 5'd0; a_wdata = 32'h77;
    rs1 = 5'd0;
    #1;
    chk("x0_a_ready", 32'(a_ready), 32'd1);
    chk("x0_rs1_busy", 32'(rs1_busy), 32'd0);
    tick();
    a_valid = 1'b0;
    chk("x0_no_wen", 32'(rf_wen), 32'd0);

    // Same-cycle issue and retire of rd=3
    b_issue = 1'b1; b_issue_rd = 5'd3;
    tick();
    b_valid = 1'b1; b_rd = 5'd3; b_wdata = 32'h33;
    #1;
    chk("same3_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_issue = 1'b0; b_valid = 1'b0;
    rs1 = 5'd3;
    chk("same3_wen", 32'(rf_wen), 32'd1);
    chk("same3_rd", 32'(rf_rd), 32'd3);
    #1;
    chk("same3_still_pending", 32'(rs1_busy), 32'd1);
    b_valid = 1'b1; b_rd = 5'd3; b_wdata = 32'h34;
    tick();
    b_valid = 1'b0;
    #1;
    chk("same3_cleared", 32'(rs1_busy), 32'd0);

    // Reset mid-transfer
    b_issue = 1'b1; b_issue_rd = 5'd12;
    tick();
    b_issue = 1'b0;
    rs2 = 5'd12;
    a_valid = 1'b1; a_rd = 5'd4; a_wdata = 32'h44;
    b_valid = 1'b1; b_rd = 5'd12; b_wdata = 32'hC0;
    #1;
    chk("rst_pre_rs2_busy", 32'(rs2_busy), 32'd1);
    repeat (4) tick();
    chk("rst_pre_wen", 32'(rf_wen), 32'd1);
    chk("rst_pre_forced", 32'(a_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wen", 32'(rf_wen), 32'd0);
    chk("rst_mid_cnt_clear", 32'(a_ready), 32'd1);
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("rst_mid_rs2_busy", 32'(rs2_busy), 32'd0);
    rs1 = 5'd12;
    #1;
    chk("rst_mid_rs1_busy", 32'(rs1_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_post_wen1", 32'(rf_wen), 32'd0);
    tick();
    chk("rst_post_wen2", 32'(rf_wen), 32'd0);
    chk("rst_post_pending", 32'(rs2_busy), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
